// File: rtl/keypad_scanner_pkg.sv
// Shared constants, key map and scan state type for the CHIP-8 keypad scanner.
package keypad_scanner_pkg;

  localparam int unsigned KEY_COUNT = 16;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned COLS      = 4;

  // Entry (4*r + c) holds the CHIP-8 key at physical row r, column c.
  localparam logic [63:0] KEY_MAP = {
    4'hF, 4'hB, 4'h0, 4'hA,
    4'hE, 4'h9, 4'h8, 4'h7,
    4'hD, 4'h6, 4'h5, 4'h4,
    4'hC, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic {
    IDLE,
    DRIVE
  } scan_state_t;

  function automatic logic [3:0] key_map(input int unsigned r, input int unsigned c);
    return KEY_MAP[4*(COLS*r + c) +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Per-key frame-based debouncer: flips its state after DEBOUNCE consecutive disagreeing frames.
module keypad_scanner_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame,
  input  logic raw_bit,
  output logic state,
  output logic toggle
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;

  // Exposed so the parent can detect rising keys on the same edge that state flips.
  assign toggle = frame && (raw_bit != state) && (cnt == CW'(DEBOUNCE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (frame) begin
      if (raw_bit == state) begin
        cnt <= '0;
      end else if (toggle) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, row sync, per-frame debounce and key_down events.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  output logic [15:0] keys,
  output logic        key_down,
  output logic [3:0]  key_code,
  output logic        frame
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  scan_state_t          state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           col_q, col_d;
  logic [KEY_COUNT-1:0] raw_q, raw_d;
  logic                 frame_d;
  logic [ROWS-1:0]      rows_meta, rows_sync;
  logic [KEY_COUNT-1:0] toggle_w;
  logic [KEY_COUNT-1:0] rise;
  logic [3:0]           code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta <= '0;
      rows_sync <= '0;
    end else begin
      rows_meta <= rows_n;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      col_q   <= '0;
      raw_q   <= '0;
      frame   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      raw_q   <= raw_d;
      frame   <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    col_d   = col_q;
    raw_d   = raw_q;
    frame_d = 1'b0;
    cols_n  = '1;
    case (state_q)
      IDLE: begin
        state_d = DRIVE;
        div_d   = '0;
        col_d   = '0;
      end
      DRIVE: begin
        cols_n = ~(4'b0001 << col_q);
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d = '0;
          for (int unsigned r = 0; r < ROWS; r++) begin
            raw_d[{col_q, 2'(r)}] = ~rows_sync[r];
          end
          col_d   = col_q + 2'd1;
          frame_d = (col_q == 2'(COLS - 1));
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each physical position feeds the debouncer owning its CHIP-8 key bit.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned KEY = int'(key_map(r, c));
      keypad_scanner_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .frame   (frame),
        .raw_bit (raw_q[COLS*c + r]),
        .state   (keys[KEY]),
        .toggle  (toggle_w[KEY])
      );
    end
  end

  always_comb begin
    rise   = toggle_w & ~keys;
    code_d = key_code;
    for (int unsigned i = KEY_COUNT; i > 0; i--) begin
      if (rise[i-1]) code_d = 4'(i - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_down <= 1'b0;
      key_code <= '0;
    end else begin
      key_down <= |rise;
      key_code <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed + randomized bench for keypad_scanner with a frame-level reference model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEBOUNCE = 3;
  localparam int unsigned TB_MAP [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [15:0] keys;
  logic        key_down;
  logic [3:0]  key_code;
  logic        frame;

  logic [15:0] press = '0;
  logic [15:0] exp_keys = '0;
  logic        exp_down = 1'b0;
  logic [3:0]  exp_code = '0;
  int          run [16];
  int          tests = 0;
  int          fails = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rows_n   (rows_n),
    .cols_n   (cols_n),
    .keys     (keys),
    .key_down (key_down),
    .key_code (key_code),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  // Matrix: a row reads low when a driven column crosses a held key.
  always_comb begin
    rows_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!cols_n[c] && press[TB_MAP[r*4 + c]]) rows_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_keys = '0;
    exp_down = 1'b0;
    exp_code = '0;
    for (int k = 0; k < 16; k++) run[k] = 0;
  endtask

  task automatic model_frame(input logic [15:0] sampled);
    logic [15:0] nxt;
    nxt = exp_keys;
    exp_down = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (sampled[k] != exp_keys[k]) run[k] = run[k] + 1;
      else run[k] = 0;
      if (run[k] == DEBOUNCE) begin
        run[k] = 0;
        nxt[k] = ~exp_keys[k];
        if (nxt[k] && !exp_down) begin
          exp_down = 1'b1;
          exp_code = 4'(k);
        end
      end
    end
    exp_keys = nxt;
  endtask

  task automatic wait_frame(output int cycles, output bit seen);
    seen = 0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cycles = i + 1;
      if (frame) begin
        seen = 1;
        break;
      end
    end
  endtask

  // Holds mask for one whole frame, then checks the update that frame produces.
  task automatic frame_step(input logic [15:0] mask);
    int cyc;
    bit seen;
    press = mask;
    wait_frame(cyc, seen);
    check("frame_seen", 32'(seen), 32'd1);
    check("frame_period", 32'(cyc), 32'd30);
    model_frame(mask);
    @(posedge clk); #1;
    check("keys", 32'(keys), 32'(exp_keys));
    check("key_down", 32'(key_down), 32'(exp_down));
    check("key_code", 32'(key_code), 32'(exp_code));
    @(posedge clk); #1;
    check("key_down_single", 32'(key_down), 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [15:0] m;
    model_reset();

    // Reset state and first column timing
    repeat (3) @(posedge clk);
    #1;
    check("rst_cols", 32'(cols_n), 32'hF);
    check("rst_keys", 32'(keys), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_col", 32'(cols_n), 32'hE);
    repeat (7) @(posedge clk);
    #1;
    check("col0_hold", 32'(cols_n), 32'hE);
    @(posedge clk); #1;
    check("second_col", 32'(cols_n), 32'hD);

    wait_frame(cyc, seen);
    check("sync_frame", 32'(seen), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Hold '1', then release it
    repeat (4) frame_step(16'h0002);
    check("hold_1_keys", 32'(keys), 32'h0002);
    check("hold_1_code", 32'(key_code), 32'h1);
    repeat (4) frame_step(16'h0000);
    check("rel_1_keys", 32'(keys), 32'h0000);
    check("rel_1_code", 32'(key_code), 32'h1);

    // Short press of '0' is filtered
    repeat (2) frame_step(16'h0001);
    repeat (3) frame_step(16'h0000);
    check("short_0_keys", 32'(keys), 32'h0000);

    // '5' and 'A' together
    repeat (3) frame_step(16'h0420);
    check("dual_keys", 32'(keys), 32'h0420);
    check("dual_code", 32'(key_code), 32'h5);
    repeat (3) frame_step(16'h0000);

    // Random held masks
    for (int t = 0; t < 8; t++) begin
      m = 16'($urandom);
      repeat ($urandom_range(1, 5)) frame_step(m);
    end
    repeat (4) frame_step(16'h0000);

    // Async reset in the middle of column 2
    repeat (3) frame_step(16'h8000);
    check("pre_rst_keys", 32'(keys), 32'h8000);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cols_n == 4'b1011) begin
        seen = 1;
        break;
      end
    end
    check("reach_col2", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    press = '0;
    #1;
    check("async_keys", 32'(keys), 32'h0);
    check("async_cols", 32'(cols_n), 32'hF);
    check("async_code", 32'(key_code), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_col", 32'(cols_n), 32'hE);
    wait_frame(cyc, seen);
    check("restart_frame", 32'(seen), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    frame_step(16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
